// File: rtl/fetch_if.sv
// fetch_if: in-order instruction-memory read channel between fetch and memory.
interface fetch_if;
   logic        MEM_REQ_VALID;
   logic        MEM_REQ_READY;
   logic [31:0] MEM_REQ_ADDR;
   logic        MEM_RESP_VALID;
   logic [31:0] MEM_RESP_DATA;
   modport master (
      output MEM_REQ_VALID, MEM_REQ_ADDR,
      input  MEM_REQ_READY, MEM_RESP_VALID, MEM_RESP_DATA
   );
   modport slave (
      input  MEM_REQ_VALID, MEM_REQ_ADDR,
      output MEM_REQ_READY, MEM_RESP_VALID, MEM_RESP_DATA
   );
endinterface

// File: rtl/fetch.sv
// fetch: sequential PC generation, in-order instruction reads and a small
// queue presenting one {pc, data} per cycle to decode, with flush/stall.
module fetch #(
   parameter logic [31:0] START_ADDR  = 32'h0000_0000,
   parameter int          QUEUE_DEPTH = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        FLUSH,
   input  logic [31:0] FLUSH_PC,
   input  logic        STALL,
   fetch_if.master     mem,
   output logic [31:0] INST_PC,
   output logic [31:0] INST_DATA
);
   localparam int AW = $clog2(QUEUE_DEPTH);
   localparam int CW = AW + 1;
   logic [31:0]   pc;
   logic [31:0]   q_pc [QUEUE_DEPTH];
   logic [31:0]   q_data [QUEUE_DEPTH];
   logic [31:0]   a_pc [QUEUE_DEPTH];
   logic [AW-1:0] head, tail, a_head, a_tail;
   logic [CW-1:0] count, outstanding, discard, live;
   logic          req_hs, resp, push, pop, show;

   // live = in-flight requests whose responses will be kept
   assign live              = outstanding - discard;
   assign mem.MEM_REQ_VALID = !RST && !FLUSH && (count + live) < CW'(QUEUE_DEPTH);
   assign mem.MEM_REQ_ADDR  = pc;
   assign req_hs            = mem.MEM_REQ_VALID && mem.MEM_REQ_READY;
   assign resp              = mem.MEM_RESP_VALID;
   assign push              = resp && discard == '0 && !FLUSH;
   assign show              = count != '0 && !FLUSH;
   assign pop               = show && !STALL;
   assign INST_PC           = show ? q_pc[head] : '0;
   assign INST_DATA         = show ? q_data[head] : '0;

   always_ff @(posedge CLK) begin
      if (req_hs) a_pc[a_tail] <= pc;
      if (push) begin
         q_pc[tail]   <= a_pc[a_head];
         q_data[tail] <= mem.MEM_RESP_DATA;
      end
   end

   // the address FIFO only tracks kept requests, so a flush simply empties it
   always_ff @(posedge CLK) begin
      if (RST) begin
         pc          <= START_ADDR;
         count       <= '0;
         outstanding <= '0;
         discard     <= '0;
         head        <= '0;
         tail        <= '0;
         a_head      <= '0;
         a_tail      <= '0;
      end else if (FLUSH) begin
         pc          <= FLUSH_PC;
         count       <= '0;
         head        <= '0;
         tail        <= '0;
         a_head      <= '0;
         a_tail      <= '0;
         outstanding <= outstanding - CW'(resp);
         discard     <= outstanding - CW'(resp);
      end else begin
         if (req_hs) pc <= pc + 32'd4;
         a_tail      <= a_tail + AW'(req_hs);
         a_head      <= a_head + AW'(push);
         tail        <= tail + AW'(push);
         head        <= head + AW'(pop);
         count       <= count + CW'(push) - CW'(pop);
         outstanding <= outstanding + CW'(req_hs) - CW'(resp);
         if (resp && discard != '0) discard <= discard - CW'(1);
      end
   end
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed scenarios for fetch against a bench-side in-order memory
// with configurable latency and optional random request back-pressure.
`timescale 1ns/1ps
module tb_fetch;
   localparam logic [31:0] START = 32'h0000_0100;
   localparam int DEPTH = 4;
   logic        CLK = 0, RST = 1, FLUSH = 0, STALL = 0;
   logic [31:0] FLUSH_PC = '0;
   logic [31:0] INST_PC, INST_DATA;
   int          checks = 0, failures = 0, cyc = 0, lat = 1;
   bit          rand_ready = 0;
   logic        mem_rst;
   typedef struct { logic [31:0] a; int due; } req_t;
   req_t mq[$];

   fetch_if m();
   fetch #(.START_ADDR(START), .QUEUE_DEPTH(DEPTH)) dut (
      .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .FLUSH_PC(FLUSH_PC), .STALL(STALL),
      .mem(m), .INST_PC(INST_PC), .INST_DATA(INST_DATA)
   );

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
   endfunction

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK)
      if (!RST && m.MEM_REQ_VALID && m.MEM_REQ_READY) mq.push_back('{m.MEM_REQ_ADDR, cyc + lat});

   // memory model: one in-order response per cycle, reset by the same RST
   initial begin
      m.MEM_REQ_READY = 1'b1; m.MEM_RESP_VALID = 1'b0; m.MEM_RESP_DATA = '0;
      forever begin
         @(posedge CLK);
         mem_rst = RST;
         #1;
         m.MEM_RESP_VALID = 1'b0; m.MEM_RESP_DATA = '0;
         if (mem_rst) mq.delete();
         else if (mq.size() > 0 && mq[0].due <= cyc) begin
            m.MEM_RESP_VALID = 1'b1; m.MEM_RESP_DATA = memf(mq[0].a);
            void'(mq.pop_front());
         end
         m.MEM_REQ_READY = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   always @(negedge CLK)
      if (!RST && !FLUSH && m.MEM_RESP_VALID && dut.discard == 0) begin
         checks++;
         if (dut.count == DEPTH) begin failures++; $display("FAIL fifo_full_resp count=%0d required<%0d", dut.count, DEPTH); end
      end

   task automatic nxt(); @(posedge CLK); #1; endtask
   task automatic smp(); @(negedge CLK); endtask

   task automatic test_reset();
      RST = 1; repeat (3) nxt(); smp();
      checks++; if (m.MEM_REQ_VALID !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", m.MEM_REQ_VALID); end
      checks++; if (m.MEM_REQ_ADDR !== START) begin failures++; $display("FAIL rst_addr got=%h exp=%h", m.MEM_REQ_ADDR, START); end
      checks++; if (INST_PC !== 0 || INST_DATA !== 0) begin failures++; $display("FAIL rst_inst pc=%h data=%h exp=0/0", INST_PC, INST_DATA); end
   endtask

   task automatic test_stream();
      nxt(); RST = 0; smp();
      checks++; if (m.MEM_REQ_VALID !== 1'b1 || m.MEM_REQ_ADDR !== START) begin failures++; $display("FAIL first_req valid=%b addr=%h exp=%h", m.MEM_REQ_VALID, m.MEM_REQ_ADDR, START); end
      nxt(); smp();
      checks++; if (INST_PC !== 0 || m.MEM_REQ_ADDR !== START + 4) begin failures++; $display("FAIL stream_c1 pc=%h addr=%h exp=0/%h", INST_PC, m.MEM_REQ_ADDR, START + 4); end
      for (int i = 0; i < 8; i++) begin
         nxt(); smp();
         checks++; if (INST_PC !== START + 32'(4 * i) || INST_DATA !== memf(START + 32'(4 * i))) begin failures++; $display("FAIL stream pc=%h data=%h exp=%h/%h", INST_PC, INST_DATA, START + 32'(4 * i), memf(START + 32'(4 * i))); end
      end
   endtask

   task automatic test_stall();
      logic [31:0] b;
      b = START + 32;
      nxt(); STALL = 1; smp();
      checks++; if (INST_PC !== b) begin failures++; $display("FAIL stall_head got=%h exp=%h", INST_PC, b); end
      for (int i = 0; i < 5; i++) begin
         nxt(); smp();
         checks++; if (INST_PC !== b || INST_DATA !== memf(b)) begin failures++; $display("FAIL stall_hold pc=%h data=%h exp=%h", INST_PC, INST_DATA, b); end
      end
      checks++; if (m.MEM_REQ_VALID !== 1'b0 || dut.count !== 3'd4) begin failures++; $display("FAIL stall_full valid=%b count=%0d exp=0/4", m.MEM_REQ_VALID, dut.count); end
      nxt(); STALL = 0; smp();
      for (int i = 0; i < 10; i++) begin
         if (i > 0) begin nxt(); smp(); end
         checks++; if (INST_PC !== b + 32'(4 * i) || INST_DATA !== memf(b + 32'(4 * i))) begin failures++; $display("FAIL stall_resume pc=%h data=%h exp=%h", INST_PC, INST_DATA, b + 32'(4 * i)); end
      end
   endtask

   task automatic test_flush();
      lat = 3;
      repeat (8) nxt();
      FLUSH = 1; FLUSH_PC = 32'h2000; smp();
      checks++; if (INST_PC !== 0 || m.MEM_REQ_VALID !== 1'b0) begin failures++; $display("FAIL flush_cycle pc=%h valid=%b exp=0/0", INST_PC, m.MEM_REQ_VALID); end
      nxt(); FLUSH = 0; smp();
      checks++; if (m.MEM_REQ_VALID !== 1'b1 || m.MEM_REQ_ADDR !== 32'h2000) begin failures++; $display("FAIL flush_req valid=%b addr=%h exp=1/2000", m.MEM_REQ_VALID, m.MEM_REQ_ADDR); end
      for (int i = 0; i < 3; i++) begin
         nxt(); smp();
         checks++; if (INST_PC !== 0 || INST_DATA !== 0) begin failures++; $display("FAIL flush_drop pc=%h data=%h exp=0/0", INST_PC, INST_DATA); end
      end
      for (int i = 0; i < 3; i++) begin
         nxt(); smp();
         checks++; if (INST_PC !== 32'h2000 + 32'(4 * i) || INST_DATA !== memf(32'h2000 + 32'(4 * i))) begin failures++; $display("FAIL flush_new pc=%h data=%h exp=%h", INST_PC, INST_DATA, 32'h2000 + 32'(4 * i)); end
         if (i == 0) begin checks++; if (dut.discard !== 3'd0) begin failures++; $display("FAIL flush_discard got=%0d exp=0", dut.discard); end end
      end
   endtask

   task automatic test_double_flush();
      lat = 2;
      repeat (10) nxt();
      FLUSH = 1; FLUSH_PC = 32'h3000; smp();
      checks++; if (INST_PC !== 0) begin failures++; $display("FAIL dflush_f0 pc=%h exp=0", INST_PC); end
      nxt(); FLUSH_PC = 32'h4000; smp();
      checks++; if (INST_PC !== 0 || m.MEM_REQ_VALID !== 1'b0) begin failures++; $display("FAIL dflush_f1 pc=%h valid=%b exp=0/0", INST_PC, m.MEM_REQ_VALID); end
      nxt(); FLUSH = 0; smp();
      checks++; if (m.MEM_REQ_VALID !== 1'b1 || m.MEM_REQ_ADDR !== 32'h4000 || INST_PC !== 0) begin failures++; $display("FAIL dflush_req valid=%b addr=%h pc=%h exp=1/4000/0", m.MEM_REQ_VALID, m.MEM_REQ_ADDR, INST_PC); end
      for (int i = 0; i < 2; i++) begin
         nxt(); smp();
         checks++; if (INST_PC !== 0 || INST_DATA !== 0) begin failures++; $display("FAIL dflush_stale pc=%h data=%h exp=0/0", INST_PC, INST_DATA); end
      end
      for (int i = 0; i < 2; i++) begin
         nxt(); smp();
         checks++; if (INST_PC !== 32'h4000 + 32'(4 * i) || INST_DATA !== memf(32'h4000 + 32'(4 * i))) begin failures++; $display("FAIL dflush_new pc=%h data=%h exp=%h", INST_PC, INST_DATA, 32'h4000 + 32'(4 * i)); end
      end
      checks++; if (dut.discard !== 3'd0) begin failures++; $display("FAIL dflush_discard got=%0d exp=0", dut.discard); end
   endtask

   task automatic test_random_ready();
      logic [31:0] e_req, e_inst, p_addr;
      logic        p_v, p_r;
      lat = 1;
      nxt(); FLUSH = 1; FLUSH_PC = 32'h5000;
      nxt(); FLUSH = 0; rand_ready = 1;
      e_req = 32'h5000; e_inst = 32'h5000; p_v = 0; p_r = 1; p_addr = '0;
      for (int i = 0; i < 80; i++) begin
         smp();
         if (p_v && !p_r) begin
            checks++; if (m.MEM_REQ_VALID !== 1'b1 || m.MEM_REQ_ADDR !== p_addr) begin failures++; $display("FAIL rr_hold valid=%b addr=%h exp=1/%h", m.MEM_REQ_VALID, m.MEM_REQ_ADDR, p_addr); end
         end
         if (m.MEM_REQ_VALID && m.MEM_REQ_READY) begin
            checks++; if (m.MEM_REQ_ADDR !== e_req) begin failures++; $display("FAIL rr_req addr=%h exp=%h", m.MEM_REQ_ADDR, e_req); end
            e_req += 4;
         end
         if (INST_PC != 0) begin
            checks++; if (INST_PC !== e_inst || INST_DATA !== memf(e_inst)) begin failures++; $display("FAIL rr_inst pc=%h data=%h exp=%h", INST_PC, INST_DATA, e_inst); end
            e_inst += 4;
         end
         p_v = m.MEM_REQ_VALID; p_r = m.MEM_REQ_READY; p_addr = m.MEM_REQ_ADDR;
         nxt();
      end
      rand_ready = 0;
      checks++; if (e_inst < 32'h5000 + 40) begin failures++; $display("FAIL rr_progress next_pc=%h required>=%h", e_inst, 32'h5000 + 40); end
   endtask

   task automatic test_rst_mid();
      lat = 3;
      repeat (6) nxt();
      RST = 1; smp();
      checks++; if (m.MEM_REQ_VALID !== 1'b0) begin failures++; $display("FAIL rstm_valid got=%b exp=0", m.MEM_REQ_VALID); end
      nxt(); RST = 0; smp();
      checks++; if (INST_PC !== 0 || INST_DATA !== 0) begin failures++; $display("FAIL rstm_inst pc=%h data=%h exp=0/0", INST_PC, INST_DATA); end
      checks++; if (m.MEM_REQ_VALID !== 1'b1 || m.MEM_REQ_ADDR !== START) begin failures++; $display("FAIL rstm_req valid=%b addr=%h exp=1/%h", m.MEM_REQ_VALID, m.MEM_REQ_ADDR, START); end
      for (int i = 0; i < 3; i++) begin
         nxt(); smp();
         checks++; if (INST_PC !== 0) begin failures++; $display("FAIL rstm_stale pc=%h exp=0", INST_PC); end
      end
      nxt(); smp();
      checks++; if (INST_PC !== START || INST_DATA !== memf(START)) begin failures++; $display("FAIL rstm_first pc=%h data=%h exp=%h/%h", INST_PC, INST_DATA, START, memf(START)); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_flush();
      test_double_flush();
      test_random_ready();
      test_rst_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
